// File: rtl/fetch_bank_sched.sv
// Bank-conflict scheduler: splits a group of up to four fetch reads into conflict-free
// rounds for the eight-bank SRAM and returns the whole group as one response.
// Optional build macro FETCH_MERGE_EN: lanes with equal addr[7:1] share one access.
module fetch_bank_sched #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 72
) (
    input  logic                  i_fire,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [4*ADDR_W-1:0]   i_req_addr,
    input  logic [3:0]            i_req_mask,
    input  logic                  i_wr_busy,
    output logic                  o_read_en,
    output logic [4*ADDR_W-1:0]   o_readAddr,
    input  logic [4*DATA_W-1:0]   i_datas,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [4*DATA_W-1:0]   o_resp_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    ready_r;
    logic                    resp_valid_r;
    logic [4*ADDR_W-1:0]     addr_r;
    logic [3:0]              pending_r;
    logic [3:0]              issued_r;
    logic [4*DATA_W-1:0]     data_r;
    logic [3:0]              issue_set_s;
    logic [ADDR_W-1:0]       low_addr_s;
    logic                    accept_s;

    // Two lanes may not share a round when they hit the same bank on different rows;
    // without merging, any shared bank is a conflict.
    function automatic logic lanes_conflict(input logic [ADDR_W-1:0] a,
                                            input logic [ADDR_W-1:0] b);
`ifdef FETCH_MERGE_EN
        lanes_conflict = (a[3:1] == b[3:1]) && (a[ADDR_W-1:1] != b[ADDR_W-1:1]);
`else
        lanes_conflict = (a[3:1] == b[3:1]);
`endif
    endfunction

    assign accept_s     = (state_r == ST_IDLE) && i_req_valid && ready_r;
    assign o_req_ready  = ready_r;
    assign o_resp_valid = resp_valid_r;
    assign o_resp_data  = data_r;

    // Issue set: a pending lane goes out unless a lower pending lane conflicts with it.
    always_comb begin
        issue_set_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            issue_set_s[k] = pending_r[k];
            for (int j = 0; j < k; j++) begin
                issue_set_s[k] = issue_set_s[k] &
                    ~(pending_r[j] & lanes_conflict(addr_r[j*ADDR_W +: ADDR_W],
                                                    addr_r[k*ADDR_W +: ADDR_W]));
            end
        end
    end

    // Address of the lowest issued lane; scanning downward lets the lowest win.
    always_comb begin
        low_addr_s = {ADDR_W{1'b0}};
        for (int k = 3; k >= 0; k--) begin
            if (issue_set_s[k]) begin
                low_addr_s = addr_r[k*ADDR_W +: ADDR_W];
            end else begin
                low_addr_s = low_addr_s;
            end
        end
    end

    // SRAM read port; idle lanes mirror the lowest issued lane to avoid stray bank selects.
    always_comb begin
        o_read_en  = 1'b0;
        o_readAddr = {(4*ADDR_W){1'b0}};
        if ((state_r == ST_ISSUE) && !i_wr_busy) begin
            o_read_en = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (issue_set_s[k]) begin
                    o_readAddr[k*ADDR_W +: ADDR_W] = addr_r[k*ADDR_W +: ADDR_W];
                end else begin
                    o_readAddr[k*ADDR_W +: ADDR_W] = low_addr_s;
                end
            end
        end else begin
            o_read_en  = 1'b0;
            o_readAddr = {(4*ADDR_W){1'b0}};
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = (i_req_mask == 4'b0000) ? ST_RESP : ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (i_wr_busy) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if ((pending_r & ~issued_r) == 4'b0000) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_RESP: begin
                if (i_resp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            ready_r      <= (next_state_s == ST_IDLE);
            resp_valid_r <= (next_state_s == ST_RESP);
        end
    end

    // Group datapath: latched addresses, pending/issued lanes and the response buffer.
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            addr_r    <= {(4*ADDR_W){1'b0}};
            pending_r <= 4'b0000;
            issued_r  <= 4'b0000;
            data_r    <= {(4*DATA_W){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r    <= i_req_addr;
                        pending_r <= i_req_mask;
                        issued_r  <= 4'b0000;
                        data_r    <= {(4*DATA_W){1'b0}};
                    end
                end
                ST_ISSUE: begin
                    if (!i_wr_busy) begin
                        issued_r <= issue_set_s;
                    end
                end
                ST_CAPTURE: begin
                    pending_r <= pending_r & ~issued_r;
                    for (int k = 0; k < 4; k++) begin
                        if (issued_r[k]) begin
                            data_r[k*DATA_W +: DATA_W] <= i_datas[k*DATA_W +: DATA_W];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
